vga_timing_gen: RTL and testbench

- Parametrised raster timing generator, successor to the fixed 640x480 timing block.
- Produces pixel/line counters, sync, data-enable and frame-event strobes for the video pipeline (sprite/tile renderers, framebuffer read, VGA pins).
- Adds a pixel clock-enable so a faster system clock can be used, programmable sync polarity, and a run/stop control.
- All outputs are registered and glitch-free.

---
 rtl/vga_timing_gen.sv | 128 ++++++++++++
 tb/tb_vga_timing_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: counters, sync, data-enable,
// active-area coordinates and frame-event strobes for the video pipeline.
//
// Ports:
//   clk, rst (async, active-low)
//   ce           pixel enable, timing advances only when ce=1
//   en           run control, 0 holds the generator at origin
//   h_cnt, v_cnt raster position
//   hsync, vsync sync outputs, asserted level set by HS_POL / VS_POL
//   de, x, y     active-area flag and coordinates (0 outside active area)
//   line_start, frame_start, vblank_start  one-clk event strobes
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int H_W      = 11,
    parameter int V_W      = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce,
    input  logic           en,
    output logic [H_W-1:0] h_cnt,
    output logic [V_W-1:0] v_cnt,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic [H_W-1:0] x,
    output logic [V_W-1:0] y,
    output logic           line_start,
    output logic           frame_start,
    output logic           vblank_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC;

    localparam logic [H_W-1:0] H_ONE = H_W'(1);
    localparam logic [V_W-1:0] V_ONE = V_W'(1);

    generate
        if (H_TOTAL > 2 ** H_W) begin : g_h_width_chk
            $error("H_W too narrow for H_TOTAL");
        end
        if (V_TOTAL > 2 ** V_W) begin : g_v_width_chk
            $error("V_W too narrow for V_TOTAL");
        end
    endgenerate

    logic           h_wrap;
    logic           v_wrap;
    logic [H_W-1:0] h_nxt;
    logic [V_W-1:0] v_nxt;
    logic           de_nxt;
    logic           hs_nxt;
    logic           vs_nxt;
    logic           vb_nxt;

    // Levels are derived from the next position so they line up with
    // the counters in the same clock.
    always_comb begin
        h_wrap = int'(h_cnt) == H_TOTAL - 1;
        v_wrap = int'(v_cnt) == V_TOTAL - 1;
        h_nxt  = h_wrap ? '0 : h_cnt + H_ONE;
        v_nxt  = v_cnt;
        if (h_wrap) begin
            v_nxt = v_wrap ? '0 : v_cnt + V_ONE;
        end
        de_nxt = (int'(h_nxt) < H_ACTIVE) && (int'(v_nxt) < V_ACTIVE);
        hs_nxt = (int'(h_nxt) >= HS_BEG) && (int'(h_nxt) < HS_END);
        vs_nxt = (int'(v_nxt) >= VS_BEG) && (int'(v_nxt) < VS_END);
        vb_nxt = h_wrap && (int'(v_cnt) == V_ACTIVE - 1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt        <= '0;
            v_cnt        <= '0;
            hsync        <= ~HS_POL;
            vsync        <= ~VS_POL;
            de           <= 1'b0;
            x            <= '0;
            y            <= '0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end else if (!en) begin
            h_cnt        <= '0;
            v_cnt        <= '0;
            hsync        <= ~HS_POL;
            vsync        <= ~VS_POL;
            de           <= 1'b0;
            x            <= '0;
            y            <= '0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end else if (ce) begin
            h_cnt        <= h_nxt;
            v_cnt        <= v_nxt;
            hsync        <= hs_nxt ? HS_POL : ~HS_POL;
            vsync        <= vs_nxt ? VS_POL : ~VS_POL;
            de           <= de_nxt;
            x            <= de_nxt ? h_nxt : '0;
            y            <= de_nxt ? v_nxt : '0;
            line_start   <= h_wrap;
            frame_start  <= h_wrap && v_wrap;
            vblank_start <= vb_nxt;
        end else begin
            // Strobes are one clk wide even when ce is sparse.
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a default 640x480 instance and
// a small active-high instance (8x4 active, 14x7 total).
module tb_vga_timing_gen;

    logic clk;
    logic rst;
    logic ce0, en0, ce1, en1;

    logic [10:0] d_h, d_x;
    logic [9:0]  d_v, d_y;
    logic        d_hs, d_vs, d_de, d_ls, d_fs, d_vb;

    logic [3:0]  s_h, s_x;
    logic [2:0]  s_v, s_y;
    logic        s_hs, s_vs, s_de, s_ls, s_fs, s_vb;

    int nchk = 0;
    int nfail = 0;

    vga_timing_gen u_def (
        .clk(clk), .rst(rst), .ce(ce0), .en(en0),
        .h_cnt(d_h), .v_cnt(d_v), .hsync(d_hs), .vsync(d_vs),
        .de(d_de), .x(d_x), .y(d_y),
        .line_start(d_ls), .frame_start(d_fs), .vblank_start(d_vb)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .H_W(4), .V_W(3)
    ) u_small (
        .clk(clk), .rst(rst), .ce(ce1), .en(en1),
        .h_cnt(s_h), .v_cnt(s_v), .hsync(s_hs), .vsync(s_vs),
        .de(s_de), .x(s_x), .y(s_y),
        .line_start(s_ls), .frame_start(s_fs), .vblank_start(s_vb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic ce;
        logic en;
        int   n;
        int   h;
        int   v;
        logic hs;
        logic vs;
        logic de;
        logic ls;
        logic fs;
        logic vb;
    } vec_t;

    vec_t tbl[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    initial begin
        int mh, mv, vb_cnt, first, second, ls_hi;
        logic [10:0] prev_h;
        logic ede;

        rst = 1'b0;
        ce0 = 1'b0; en0 = 1'b1;
        ce1 = 1'b0; en1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_h", 32'(d_h), 0);
        chk("rst_v", 32'(d_v), 0);
        chk("rst_hs", 32'(d_hs), 1);
        chk("rst_vs", 32'(d_vs), 1);
        chk("rst_de", 32'(d_de), 0);
        chk("rst_strb", 32'({d_ls, d_fs, d_vb}), 0);
        chk("rst_s_sync", 32'({s_hs, s_vs}), 0);
        @(negedge clk);
        rst = 1'b1;

        // ce, en, n, h, v, hs, vs, de, ls, fs, vb
        tbl.push_back('{1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{0, 1, 3, 1, 0, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{1, 1, 7, 8, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 2, 10, 0, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 11, 0, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 12, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 2, 0, 1, 0, 0, 1, 1, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{1, 1, 28, 0, 3, 0, 0, 1, 1, 0, 0});
        tbl.push_back('{1, 1, 14, 0, 4, 0, 0, 0, 1, 0, 1});
        tbl.push_back('{1, 1, 14, 0, 5, 0, 1, 0, 1, 0, 0});
        tbl.push_back('{1, 1, 13, 13, 5, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 0, 6, 0, 0, 0, 1, 0, 0});
        tbl.push_back('{1, 1, 14, 0, 0, 0, 0, 1, 1, 1, 0});
        tbl.push_back('{1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{1, 1, 12, 13, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 0, 1, 0, 0, 1, 1, 0, 0});

        foreach (tbl[i]) begin
            ce1 = tbl[i].ce;
            en1 = tbl[i].en;
            repeat (tbl[i].n) tick();
            chk($sformatf("v%0d_h", i), 32'(s_h), 32'(tbl[i].h));
            chk($sformatf("v%0d_v", i), 32'(s_v), 32'(tbl[i].v));
            chk($sformatf("v%0d_hs", i), 32'(s_hs), 32'(tbl[i].hs));
            chk($sformatf("v%0d_vs", i), 32'(s_vs), 32'(tbl[i].vs));
            chk($sformatf("v%0d_de", i), 32'(s_de), 32'(tbl[i].de));
            chk($sformatf("v%0d_x", i), 32'(s_x),
                tbl[i].de ? 32'(tbl[i].h) : 0);
            chk($sformatf("v%0d_y", i), 32'(s_y),
                tbl[i].de ? 32'(tbl[i].v) : 0);
            chk($sformatf("v%0d_ls", i), 32'(s_ls), 32'(tbl[i].ls));
            chk($sformatf("v%0d_fs", i), 32'(s_fs), 32'(tbl[i].fs));
            chk($sformatf("v%0d_vb", i), 32'(s_vb), 32'(tbl[i].vb));
        end

        // Small: abandon frame, then one whole frame from origin.
        en1 = 1'b0;
        tick();
        chk("s_drop_pos", 32'({s_h, 1'b0, s_v}), 0);
        en1 = 1'b1;
        ce1 = 1'b1;
        mh = 0; mv = 0; vb_cnt = 0;
        for (int c = 1; c <= 98; c++) begin
            tick();
            if (mh == 13) begin
                mh = 0;
                mv = (mv == 6) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            ede = (mh < 8) && (mv < 4);
            if (s_vb) vb_cnt++;
            chk("s_fr_h", 32'(s_h), 32'(mh));
            chk("s_fr_v", 32'(s_v), 32'(mv));
            chk("s_fr_hs", 32'(s_hs), 32'(mh >= 10 && mh <= 11));
            chk("s_fr_vs", 32'(s_vs), 32'(mv == 5));
            chk("s_fr_x", 32'(s_x), ede ? 32'(mh) : 0);
            chk("s_fr_y", 32'(s_y), ede ? 32'(mv) : 0);
            chk("s_fr_fs", 32'(s_fs), 32'(mh == 0 && mv == 0));
        end
        chk("s_vb_once", 32'(vb_cnt), 1);
        ce1 = 1'b0;

        // Default instance: one full line at ce=1.
        ce0 = 1'b1;
        for (int k = 1; k < 800; k++) begin
            tick();
            chk("d_l0_h", 32'(d_h), 32'(k));
            chk("d_l0_hs", 32'(d_hs), 32'(!(k >= 656 && k < 752)));
            chk("d_l0_de", 32'(d_de), 32'(k < 640));
        end
        tick();
        chk("d_wrap_h", 32'(d_h), 0);
        chk("d_wrap_v", 32'(d_v), 1);
        chk("d_wrap_ls", 32'(d_ls), 1);
        chk("d_wrap_fs", 32'(d_fs), 0);
        chk("d_wrap_de", 32'(d_de), 1);

        // Half-rate ce: line period and strobe width.
        first = 0; second = 0; ls_hi = 0;
        for (int c = 1; c <= 5000; c++) begin
            ce0 = c[0];
            prev_h = d_h;
            tick();
            if (!ce0) chk("d_ce0_hold", 32'(d_h), 32'(prev_h));
            if (d_ls) begin
                ls_hi++;
                if (first == 0) first = c;
                else second = c;
            end
            if (second != 0) break;
        end
        chk("d_half_bound", 32'(second != 0), 1);
        chk("d_half_period", 32'(second - first), 1600);
        chk("d_half_width", 32'(ls_hi), 2);
        chk("d_half_pos", 32'({d_h, 1'b0, d_v}), 3);

        // Default: drop en at (300,3).
        ce0 = 1'b1;
        repeat (300) tick();
        chk("d_pre_drop_h", 32'(d_h), 300);
        en0 = 1'b0;
        tick();
        chk("d_drop_h", 32'(d_h), 0);
        chk("d_drop_v", 32'(d_v), 0);
        chk("d_drop_sync", 32'({d_hs, d_vs}), 3);
        chk("d_drop_de", 32'(d_de), 0);
        chk("d_drop_xy", 32'({d_x, d_y}), 0);
        chk("d_drop_strb", 32'({d_ls, d_fs, d_vb}), 0);
        repeat (4) tick();
        chk("d_held_h", 32'(d_h), 0);
        en0 = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("d_resume_h", 32'(d_h), 32'(k));
            chk("d_resume_ls", 32'(d_ls), 0);
        end

        // Async reset between edges.
        repeat (20) tick();
        #2;
        rst = 1'b0;
        #1;
        chk("ar_h", 32'(d_h), 0);
        chk("ar_v", 32'(d_v), 0);
        chk("ar_sync", 32'({d_hs, d_vs}), 3);
        chk("ar_de", 32'(d_de), 0);
        chk("ar_x", 32'(d_x), 0);
        chk("ar_s_sync", 32'({s_hs, s_vs}), 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("ar_first_h", 32'(d_h), 1);
        chk("ar_first_de", 32'(d_de), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
